// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and default parameters for the data memory controller
//
// Purpose: controller state encoding and default geometry/latency values,
//          shared by the controller, its storage array and the bus interface.
// Ports:   none (package).

package data_mem_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_DEPTH       = 64;
    localparam int DEFAULT_WAIT_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - request/response bus between a requester and the data memory controller
//
// Purpose: groups the handshake and data signals of one memory port.
// Signals:
//   mem_read, mem_write  request strobes, held by the requester until ready
//   address, data        word address and write data
//   byte_en              write byte lanes, bit i covers data[8i+7:8i]
//   mem_result           registered read data
//   ready                one-cycle completion pulse
//   busy                 controller is not idle
//   conflict             sticky: a simultaneous read+write request was accepted
// Modports: master (requester side), slave (controller side).

interface data_mem_if
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEFAULT_DEPTH)
);

    logic                      mem_read;
    logic                      mem_write;
    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   byte_en;
    logic [DATA_WIDTH-1:0]     mem_result;
    logic                      ready;
    logic                      busy;
    logic                      conflict;

    modport master (
        output mem_read,
        output mem_write,
        output address,
        output data,
        output byte_en,
        input  mem_result,
        input  ready,
        input  busy,
        input  conflict
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  address,
        input  data,
        input  byte_en,
        output mem_result,
        output ready,
        output busy,
        output conflict
    );

endinterface

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word storage with byte-masked write and optional clear on reset
//
// Purpose: DEPTH x DATA_WIDTH register array. Writes are synchronous and
//          byte-masked; the read port is combinational so the controller can
//          register the word on the same edge it performs the access.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   we         write strobe (one cycle)
//   addr       word address for both read and write
//   wdata      write data
//   be         write byte lanes
//   rdata      combinational read data at addr

module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int  DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int  DEPTH          = DEFAULT_DEPTH,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int ADDR_WIDTH     = $clog2(DEPTH),
    localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset wins over a write; without CLEAR_ON_RESET the contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
        end else if (we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - fixed-latency data memory controller (IDLE -> WAIT -> DONE)
//
// Purpose: accepts one read or write request in IDLE, latches it, waits
//          WAIT_CYCLES clocks from acceptance, performs the access on the
//          storage array and pulses ready for one cycle.
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   bus    data_mem_if slave modport (requests in, result/ready/busy/conflict out)

module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int  DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int  DEPTH          = DEFAULT_DEPTH,
    parameter int  WAIT_CYCLES    = DEFAULT_WAIT_CYCLES,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int ADDR_WIDTH     = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst,
    data_mem_if.slave bus
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    // Counter holds WAIT_CYCLES-1 down to 0; keep at least one bit for WAIT_CYCLES=1.
    localparam int CNT_WIDTH = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic                  is_write_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  conflict_q;
    logic                  accept;
    logic                  access;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Only the latched copies feed the access, so the requester may change
    // its inputs freely once the request has been taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
            is_write_q <= 1'b0;
            result_q   <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt        <= CNT_WIDTH'(WAIT_CYCLES - 1);
                addr_q     <= bus.address;
                data_q     <= bus.data;
                be_q       <= bus.byte_en;
                // Simultaneous read+write collapses to a write.
                is_write_q <= bus.mem_write;
                if (bus.mem_read && bus.mem_write) begin
                    conflict_q <= 1'b1;
                end
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (access && !is_write_q) begin
                result_q <= rd_data;
            end
        end
    end

    // Gate with rst so an access landing on a reset edge is dropped even
    // when the array keeps its contents through reset.
    assign mem_we = access && is_write_q && !rst;

    data_mem_array #(
        .DATA_WIDTH     (DATA_WIDTH),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (data_q),
        .be    (be_q),
        .rdata (rd_data)
    );

    assign bus.mem_result = result_q;
    assign bus.ready      = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.conflict   = conflict_q;

endmodule
